// File: rtl/barrel_shift_right_logical.sv
// -----------------------------------------------------------------------------
// barrel_shift_right_logical
//
// 64-bit logical right barrel shifter for SRL/SRLI-class ALU operations.
// The operand is shifted right by the low 6 bits of the shift operand and the
// vacated MSBs are zero-filled. The shift runs through a 6-level logarithmic
// mux tree, and the result is registered, giving one cycle of latency. A
// valid flag is registered alongside the data.
//
// Handshake: in_valid qualifies data/_shift on a rising edge. out_valid is
// high for exactly the one cycle after each capture. There is no ready signal
// and no backpressure, so every accepted input yields exactly one output.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   qualifies data/_shift for capture this cycle
//   data       in   64  operand to shift
//   _shift     in   64  shift amount; only bits [5:0] are used
//   out        out  64  registered result, data >> _shift[5:0], zero-filled
//   out_valid  out  1   high the cycle after an in_valid capture
// -----------------------------------------------------------------------------
module barrel_shift_right_logical (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] data,
    input  logic [63:0] _shift,
    output logic [63:0] out,
    output logic        out_valid
);

    // Only the low six bits select the amount. The upper bits are folded
    // into a deliberately unused net so they visibly do not reach the result.
    logic [5:0] sh;
    logic       unused_shift_hi;

    assign sh              = _shift[5:0];
    assign unused_shift_hi = ^_shift[63:6];

    // Mux tree: level k shifts right by 2^k when sh[k] is set.
    // Levels are applied in order 1, 2, 4, 8, 16, 32.
    logic [63:0] lvl0;
    logic [63:0] lvl1;
    logic [63:0] lvl2;
    logic [63:0] lvl3;
    logic [63:0] lvl4;
    logic [63:0] lvl5;
    logic [63:0] lvl6;

    assign lvl0 = data;
    assign lvl1 = sh[0] ? {1'b0,  lvl0[63:1]}  : lvl0;
    assign lvl2 = sh[1] ? {2'b0,  lvl1[63:2]}  : lvl1;
    assign lvl3 = sh[2] ? {4'b0,  lvl2[63:4]}  : lvl2;
    assign lvl4 = sh[3] ? {8'b0,  lvl3[63:8]}  : lvl3;
    assign lvl5 = sh[4] ? {16'b0, lvl4[63:16]} : lvl4;
    assign lvl6 = sh[5] ? {32'b0, lvl5[63:32]} : lvl5;

    // Output register next-state: load on a valid capture, otherwise hold.
    // The valid flag simply follows in_valid, so it drops after an idle edge.
    logic [63:0] out_d;
    logic [63:0] out_q;
    logic        out_valid_d;
    logic        out_valid_q;

    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = lvl6;
        end
    end

    // Reset clears both registers immediately and discards any result that
    // would have been captured on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= 64'h0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shift_right_logical.sv
// -----------------------------------------------------------------------------
// Testbench for barrel_shift_right_logical.
// Drivers issue operations on the falling edge and push the expected result
// into exp_q. A monitor samples 1 time unit after each rising edge, pops the
// queue whenever out_valid is high, and otherwise checks that out holds.
// -----------------------------------------------------------------------------
module tb_barrel_shift_right_logical;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] data_s;
  logic [63:0] shift_s;
  logic [63:0] out_s;
  logic        out_valid_s;

  logic [63:0] exp_q[$];
  logic [63:0] hold_exp;
  int          checks;
  int          failures;

  barrel_shift_right_logical dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data      (data_s),
    ._shift    (shift_s),
    .out       (out_s),
    .out_valid (out_valid_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Bit i of the result is data bit i+sh when that bit exists, else zero.
  function automatic logic [63:0] ref_srl(input logic [63:0] d, input logic [63:0] s);
    logic [63:0] r;
    int          amt;
    amt = int'(s % 64);
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i + amt <= 63) r[i] = d[i + amt];
    end
    return r;
  endfunction

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [63:0] d, input logic [63:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    data_s   = d;
    shift_s  = s;
    if (!rst) exp_q.push_back(ref_srl(d, s));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    data_s   = {$urandom, $urandom};
    shift_s  = {$urandom, $urandom};
  endtask

  // Assert reset between edges while a valid item is pending, check the
  // outputs clear without a clock edge, and drop the in-flight result.
  task automatic mid_reset(input logic [63:0] d, input logic [63:0] s);
    drive(d, s);
    #2;
    rst = 1'b1;
    exp_q.delete();
    hold_exp = 64'h0;
    #1;
    check64("async_reset_out", out_s, 64'h0);
    check1("async_reset_valid", out_valid_s, 1'b0);
    // in_valid stays high across the next edge; reset must win.
    @(negedge clk);
    check64("reset_wins_out", out_s, 64'h0);
    check1("reset_wins_valid", out_valid_s, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(posedge clk);
    #1;
    if (out_valid_s) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got out_valid=1 out=%h expected out_valid=0 at %0t", out_s, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check64("result", out_s, e);
        hold_exp = e;
      end
    end else begin
      if (!rst && exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL missing_valid: got out_valid=0 expected out_valid=1 (%0d pending) at %0t", exp_q.size(), $time);
        void'(exp_q.pop_front());
      end
      check64("hold", out_s, hold_exp);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  initial begin
    checks   = 0;
    failures = 0;
    hold_exp = 64'h0;
    rst      = 1'b1;
    in_valid = 1'b0;
    data_s   = 64'h0;
    shift_s  = 64'h0;
    #1;
    check64("reset_out", out_s, 64'h0);
    check1("reset_valid", out_valid_s, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();

    // Identity, small, multi-level and large shifts.
    drive(MSB, 64'd0);   idle();
    drive(MSB, 64'd1);   idle();
    drive(MSB, 64'd4);   idle();
    drive(MSB, 64'd13);
    drive(MSB, 64'd32);
    drive(MSB, 64'd63);
    // Upper shift bits are masked off.
    drive(MSB, 64'd65);
    drive(MSB, 64'hFFFF_FFFF_FFFF_FFC0);
    // Zero fill and pattern.
    drive(64'h1, 64'd1);
    drive(64'hA0A0_A0A0_A0A0_A0A0, 64'd4);
    idle();
    idle();
    // Directed spot checks against hand-computed values, independent of the model.
    drive(MSB, 64'd13);
    @(posedge clk); #2;
    check64("spot_sh13", out_s, 64'h0004_0000_0000_0000);
    drive(64'hA0A0_A0A0_A0A0_A0A0, 64'd4);
    @(posedge clk); #2;
    check64("spot_pattern", out_s, 64'h0A0A_0A0A_0A0A_0A0A);
    drive(MSB, 64'd63);
    @(posedge clk); #2;
    check64("spot_sh63", out_s, 64'h0000_0000_0000_0001);
    drive(MSB, 64'hFFFF_FFFF_FFFF_FFC0);
    @(posedge clk); #2;
    check64("spot_mask", out_s, MSB);

    // Streaming: three back-to-back, then idle so the monitor checks hold.
    drive(64'hDEAD_BEEF_0123_4567, 64'd8);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd60);
    drive(64'h0123_4567_89AB_CDEF, 64'd20);
    repeat (3) idle();

    // Reset during streaming, then recovery.
    drive(64'h1111_2222_3333_4444, 64'd3);
    mid_reset(64'h5555_6666_7777_8888, 64'd5);
    drive(64'hCAFE_F00D_1234_5678, 64'd16);
    repeat (2) idle();

    // Randomized traffic with occasional idles.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] d;
      logic [63:0] s;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: s = {$urandom, $urandom};
        1: s = 64'($urandom_range(0, 63));
        2: s = {58'h0, 6'd63};
        default: s = 64'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 3) == 0) idle();
      else drive(d, s);
      if (n == 200) mid_reset({$urandom, $urandom}, 64'($urandom_range(0, 63)));
    end
    repeat (3) idle();

    check1("queue_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_shift_right_logical.md
# barrel_shift_right_logical

64-bit logical right barrel shifter used by the ALU for SRL/SRLI-class operations. It shifts a 64-bit operand right by the amount in the low 6 bits of a 64-bit shift operand and zero-fills from the MSB. The shift network is a 6-level logarithmic mux tree with a registered output, giving one cycle of latency, and a valid flag travels alongside the data.

## Interface
- Parameters: none. Widths are fixed: data 64 bits, effective shift amount 6 bits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies data/_shift for capture this cycle.
- data  input  64  operand to shift.
- _shift  input  64  shift amount; only bits [5:0] are used, bits [63:6] are ignored.
- out  output  64  registered result, data >> _shift[5:0], zero-filled.
- out_valid  output  1  high the cycle after an in_valid capture.

## Operation
- Effective amount: sh = _shift[5:0], range 0–63. Upper bits never influence the result, so a shift amount of 65 behaves as 1 and 64 behaves as 0.
- Logical shift: out[i] = data[i+sh] for i+sh ≤ 63, otherwise 0. There is no sign extension.
- Network: six cascaded 2:1 mux levels. Level k (k = 0..5) shifts right by 2^k when sh[k] = 1 and passes the value through otherwise. The levels are applied in order 1, 2, 4, 8, 16, 32. All levels are combinational.
- sh = 0 is the identity, with out = data.
- sh = 63 gives out = {63'b0, data[63]}.
- Output register:
  - When in_valid = 1 on a rising edge, out loads the network result and out_valid is set to 1.
  - When in_valid = 0 on a rising edge, out holds its previous value and out_valid is cleared to 0.
- No internal state exists beyond the out and out_valid registers. There is no backpressure: every valid input produces exactly one valid output.

## Timing
- Latency is 1 cycle, from input sampled at edge N to result on out after edge N.
- Throughput is one operation per cycle. Back-to-back in_valid produces back-to-back out_valid with the matching results in order.
- Reset:
  - Asserting rst forces out = 64'h0 and out_valid = 0 immediately, with no dependence on clk.
  - While rst is high, inputs are ignored.
  - Reset asserted mid-stream discards the in-flight result.
  - The first capture after reset is the first rising edge with rst low and in_valid high.
- in_valid and rst may assert together; rst wins.
- The combinational path runs data/_shift → 6 mux levels → out register D-input. No input is registered before the mux tree.

## Test plan
- Identity and small shifts: data = 0x8000_0000_0000_0000 with sh = 0, 1, 4 → out = 0x8000_0000_0000_0000, 0x4000_0000_0000_0000, 0x0800_0000_0000_0000, each with out_valid one cycle after in_valid.
- Multi-level and large shifts: same data with sh = 13, 32, 63 → out = 0x0004_0000_0000_0000, 0x0000_0000_8000_0000, 0x0000_0000_0000_0001.
- Mask check: same data with _shift = 65 → out = 0x4000_0000_0000_0000. Then _shift = 0xFFFF_FFFF_FFFF_FFC0 → out = data unchanged.
- Zero fill and pattern:
  - data = 0x1, sh = 1 → out = 0x0.
  - data = 0xA0A0_A0A0_A0A0_A0A0, sh = 4 → out = 0x0A0A_0A0A_0A0A_0A0A.
- Streaming and hold:
  - Apply 3 back-to-back valid inputs; the 3 correct results must appear on consecutive cycles.
  - Then drop in_valid: out_valid → 0 and out holds the last result.
- Reset:
  - Assert rst asynchronously between edges during streaming: out = 0 and out_valid = 0 immediately.
  - After release, the first valid input yields its correct result one cycle later.
